xmem_server: RTL and testbench
==============================

# xmem_server

Responder end of the `mem_intf_read` / `mem_intf_write` protocol: the XMEM-side block that services byte-granular, possibly unaligned line requests from accelerator clients such as the memcpy engines. It owns one single-port, line-wide SRAM bank and arbitrates between one read client and one write client. It splits accesses that cross a line boundary into two bank cycles and answers with a registered, single-cycle `mem_valid` (reads) or `mem_ack` (writes).

## Interface
- `XMEM_ADDR_WIDTH`, package value: byte address width.
- `BYTES_PER_MEM_LINE`, package value (32): bytes per bank line; power of two.
- `clk`  in  1  clock, single domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_intf_read`  modport `server_read`:
  - in: `mem_req`, `mem_start_addr[XMEM_ADDR_WIDTH]`, `mem_size_bytes[$clog2(B)+1]`.
  - out: `mem_valid`, `mem_data[B][8]`.
- `mem_intf_write`  modport `server_write`:
  - in: `mem_req`, `mem_start_addr`, `mem_size_bytes`, `mem_data[B][8]`.
  - out: `mem_ack`.

## Operation
- Address split:
  - line = `addr[AW-1:OFS_W]`, offset = `addr[OFS_W-1:0]`, with OFS_W = log2(B).
  - size_eff = min(`mem_size_bytes`, B).
  - span = (offset + size_eff > B).
  - Second line = line+1, modulo bank depth (wraps to line 0).
- States: IDLE, RD0, RD1, RD_CAP, RD_RSP, WR0, WR1, WR_RSP.
- IDLE arbitration:
  - If exactly one `mem_req` is high, serve it.
  - If both are high, serve the port not served last. The last-served flag resets to "read", so write wins first.
  - On acceptance, latch addr, size_eff, span, offset and write data; the client's inputs are don't-care afterwards.
- Read path:
  - RD0 issues a bank read of line0.
  - If span: RD1 issues line1 and captures line0.
  - RD_CAP captures the final line and merges: `mem_data[i]` = byte(addr+i) for i < size_eff, else 0x00.
  - Register `mem_data`, then go to RD_RSP.
  - RD_RSP: `mem_valid`=1 for exactly one cycle, then IDLE.
- Write path:
  - WR0 writes line0 with byte enables for bytes offset .. min(offset+size_eff, B)-1. Source byte j lands at line byte offset+j.
  - If span: WR1 writes the remaining bytes into line1, starting at byte 0.
  - WR_RSP: `mem_ack`=1 for exactly one cycle, then IDLE.
- size 0:
  - Read: no bank access, path goes through RD0/RD_CAP unchanged, returns all-zero data.
  - Write: zero byte enables; still acked.
- `mem_req` is never sampled outside IDLE, so a request held through the response cycle is not served twice.
- `mem_data` holds its last value between responses.

## Timing
- Request is accepted in IDLE at cycle t.
- Read latency:
  - Single line: `mem_valid` at t+3.
  - Two lines: `mem_valid` at t+4.
- Write latency:
  - Single line: `mem_ack` at t+2.
  - Two lines: `mem_ack` at t+3.
- Earliest next acceptance is the cycle after the response pulse.
- Outputs are registered; no combinational path from `mem_req` to `mem_valid` or `mem_ack`. This is required because clients drop `mem_req` combinationally on `mem_valid`/`mem_ack`.
- Reset values:
  - `mem_valid`=0, `mem_ack`=0, `mem_data`=0.
  - state = IDLE, last-served = read.
  - Bank contents are not reset.
- Reset mid-operation (any state): return to IDLE immediately, no response is issued, and a partially written span may remain. The client must re-issue the request.

## Structure
- Add to `xbox_def_pkg`:
  - `XMEM_OFS_WIDTH` = $clog2(BYTES_PER_MEM_LINE).
  - `XMEM_LINE_IDX_WIDTH` = XMEM_ADDR_WIDTH - XMEM_OFS_WIDTH.
  - `typedef logic [BYTES_PER_MEM_LINE-1:0][7:0] mem_line_t`.
- Keep the state enum local to the block.
- One sub-module, `xmem_line_bank`:
  - Single-port synchronous SRAM, 2^XMEM_LINE_IDX_WIDTH lines × `mem_line_t`.
  - Per-byte write enable.
  - One-cycle read latency, no reset.

## Test plan
- Write 0x40, size 32, bytes 0x00..0x1F → `mem_ack` at t+2. Then read 0x40, size 32 → `mem_valid` at t+3, data 0x00..0x1F.
- Fill lines 0x40 and 0x60 with bytes equal to address[7:0], then read 0x5C, size 8 → `mem_valid` at t+4, data 5C..63, bytes 8..31 = 0x00.
- Write 0x45, size 3, data AA BB CC → ack at t+2. Read line 0x40: only bytes 5–7 changed. Write 0x5E, size 4 (span) → ack at t+3, and 0x60/0x61 are updated.
- Both requests high in the first IDLE after reset (write 0x80 ← 0x11s, read 0x80) → ack first, then read returns 0x11s. Hold both again → read is served before write.
- Read size 0 → `mem_valid`, all-zero data. Write size 40 → clamped to 32 bytes, 0x60.. untouched beyond line. Read at top line offset 28, size 8 → bytes 4..7 come from line 0.
- Assert `rst_n` low during RD1 → `mem_valid` never pulses and all outputs are 0. After release, a fresh read of 0x40 completes at t+3.

Source files
------------

// File: rtl/xbox_def_pkg.sv
// Shared XMEM definitions: address geometry, line type and a byte-count mask helper.
package xbox_def_pkg;
  localparam int XMEM_ADDR_WIDTH     = 12;
  localparam int BYTES_PER_MEM_LINE  = 32;
  localparam int XMEM_OFS_WIDTH      = $clog2(BYTES_PER_MEM_LINE);
  localparam int XMEM_LINE_IDX_WIDTH = XMEM_ADDR_WIDTH - XMEM_OFS_WIDTH;
  localparam int XMEM_SIZE_WIDTH     = XMEM_OFS_WIDTH + 1;

  typedef logic [BYTES_PER_MEM_LINE-1:0][7:0] mem_line_t;

  // Bit i set for every byte index i below sz.
  function automatic logic [BYTES_PER_MEM_LINE-1:0] size_mask(input logic [XMEM_SIZE_WIDTH-1:0] sz);
    logic [BYTES_PER_MEM_LINE-1:0] m;
    for (int i = 0; i < BYTES_PER_MEM_LINE; i++)
      m[i] = (XMEM_SIZE_WIDTH'(i) < sz);
    return m;
  endfunction
endpackage

// File: rtl/mem_intf.sv
// Read and write request/response bundles between XMEM clients and the server.
interface mem_intf_read;
  import xbox_def_pkg::*;
  logic                       mem_req;
  logic [XMEM_ADDR_WIDTH-1:0] mem_start_addr;
  logic [XMEM_SIZE_WIDTH-1:0] mem_size_bytes;
  logic                       mem_valid;
  mem_line_t                  mem_data;

  modport server_read (input mem_req, mem_start_addr, mem_size_bytes, output mem_valid, mem_data);
  modport client_read (output mem_req, mem_start_addr, mem_size_bytes, input mem_valid, mem_data);
endinterface

interface mem_intf_write;
  import xbox_def_pkg::*;
  logic                       mem_req;
  logic [XMEM_ADDR_WIDTH-1:0] mem_start_addr;
  logic [XMEM_SIZE_WIDTH-1:0] mem_size_bytes;
  mem_line_t                  mem_data;
  logic                       mem_ack;

  modport server_write (input mem_req, mem_start_addr, mem_size_bytes, mem_data, output mem_ack);
  modport client_write (output mem_req, mem_start_addr, mem_size_bytes, mem_data, input mem_ack);
endinterface

// File: rtl/xmem_line_bank.sv
// Single-port line-wide SRAM with per-byte write enables and one-cycle read latency.
module xmem_line_bank
  import xbox_def_pkg::*;
(
  input  logic                           clk,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [XMEM_LINE_IDX_WIDTH-1:0] addr_i,
  input  logic [BYTES_PER_MEM_LINE-1:0]  be_i,
  input  mem_line_t                      wdata_i,
  output mem_line_t                      rdata_o
);
  localparam int DEPTH = 1 << XMEM_LINE_IDX_WIDTH;

  mem_line_t mem_q [DEPTH];
  mem_line_t rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BYTES_PER_MEM_LINE; b++)
          if (be_i[b]) mem_q[addr_i][b] <= wdata_i[b];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/xmem_server.sv
// XMEM responder: arbitrates one read and one write client onto a single line bank,
// splitting line-crossing accesses into two bank cycles.
module xmem_server
  import xbox_def_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  mem_intf_read.server_read   rd_if,
  mem_intf_write.server_write wr_if
);
  localparam int B  = BYTES_PER_MEM_LINE;
  localparam int AW = XMEM_ADDR_WIDTH;
  localparam int OW = XMEM_OFS_WIDTH;
  localparam int LW = XMEM_LINE_IDX_WIDTH;
  localparam int SW = XMEM_SIZE_WIDTH;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD_CAP, RD_RSP, WR0, WR1, WR_RSP} state_e;

  state_e        state_q;
  logic          last_wr_q, span_q, valid_q, ack_q;
  logic [LW-1:0] line0_q;
  logic [OW-1:0] ofs_q;
  logic [SW-1:0] size_q;
  mem_line_t     wdata_q, lo_q, rdata_q;

  logic          pick_wr, pick_rd, acc_span;
  logic [AW-1:0] acc_addr;
  logic [SW-1:0] acc_size, size_eff;

  // Ties go to the port that was not served last.
  always_comb begin
    pick_wr  = wr_if.mem_req & (~rd_if.mem_req | ~last_wr_q);
    pick_rd  = rd_if.mem_req & ~pick_wr;
    acc_addr = pick_wr ? wr_if.mem_start_addr : rd_if.mem_start_addr;
    acc_size = pick_wr ? wr_if.mem_size_bytes : rd_if.mem_size_bytes;
    size_eff = (acc_size > SW'(B)) ? SW'(B) : acc_size;
    acc_span = ((SW+1)'(acc_addr[OW-1:0]) + (SW+1)'(size_eff)) > (SW+1)'(B);
  end

  logic [LW-1:0]      line1;
  logic [2*B*8-1:0]   wr_wide;
  logic [2*B-1:0]     be_wide;
  logic               bank_en, bank_we;
  logic [LW-1:0]      bank_addr;
  logic [B-1:0]       bank_be;
  mem_line_t          bank_wdata, bank_rdata;

  // Shifting the source into a two-line window gives both halves of a split write at once.
  assign line1   = line0_q + LW'(1);
  assign wr_wide = {{(B*8){1'b0}}, wdata_q} << {ofs_q, 3'b000};
  assign be_wide = {{B{1'b0}}, size_mask(size_q)} << ofs_q;

  always_comb begin
    bank_en    = 1'b0;
    bank_we    = 1'b0;
    bank_addr  = line0_q;
    bank_be    = '0;
    bank_wdata = wr_wide[B*8-1:0];
    case (state_q)
      RD0: bank_en = (size_q != '0);
      RD1: begin
        bank_en   = 1'b1;
        bank_addr = line1;
      end
      WR0: begin
        bank_en = 1'b1;
        bank_we = 1'b1;
        bank_be = be_wide[B-1:0];
      end
      WR1: begin
        bank_en    = 1'b1;
        bank_we    = 1'b1;
        bank_addr  = line1;
        bank_be    = be_wide[2*B-1:B];
        bank_wdata = wr_wide[2*B*8-1:B*8];
      end
      default: ;
    endcase
  end

  xmem_line_bank u_bank (
    .clk     (clk),
    .en_i    (bank_en),
    .we_i    (bank_we),
    .addr_i  (bank_addr),
    .be_i    (bank_be),
    .wdata_i (bank_wdata),
    .rdata_o (bank_rdata)
  );

  logic [2*B-1:0][7:0] rd_cat;
  logic [B-1:0]        rd_mask;
  mem_line_t           rd_merged;

  always_comb begin
    rd_cat    = {bank_rdata, (span_q ? lo_q : bank_rdata)};
    rd_mask   = size_mask(size_q);
    rd_merged = '0;
    for (int i = 0; i < B; i++)
      if (rd_mask[i]) rd_merged[i] = rd_cat[{1'b0, ofs_q} + (OW+1)'(i)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      span_q    <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      line0_q   <= '0;
      ofs_q     <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      rdata_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      case (state_q)
        IDLE: if (pick_wr | pick_rd) begin
          line0_q   <= acc_addr[AW-1:OW];
          ofs_q     <= acc_addr[OW-1:0];
          size_q    <= size_eff;
          span_q    <= acc_span;
          last_wr_q <= pick_wr;
          if (pick_wr) begin
            wdata_q <= wr_if.mem_data;
            state_q <= WR0;
          end else begin
            state_q <= RD0;
          end
        end
        RD0:    state_q <= span_q ? RD1 : RD_CAP;
        RD1: begin
          lo_q    <= bank_rdata;
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          rdata_q <= rd_merged;
          valid_q <= 1'b1;
          state_q <= RD_RSP;
        end
        RD_RSP: state_q <= IDLE;
        WR0: begin
          if (span_q) begin
            state_q <= WR1;
          end else begin
            ack_q   <= 1'b1;
            state_q <= WR_RSP;
          end
        end
        WR1: begin
          ack_q   <= 1'b1;
          state_q <= WR_RSP;
        end
        WR_RSP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_if.mem_valid = valid_q;
  assign rd_if.mem_data  = rdata_q;
  assign wr_if.mem_ack   = ack_q;
endmodule

// File: tb/tb_xmem_server.sv
// Bench for xmem_server: directed vector table, arbitration and reset sequences,
// and random traffic checked against a flat byte-array memory model.
module tb_xmem_server;
  import xbox_def_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_intf_read  rd();
  mem_intf_write wr();

  xmem_server dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_if (rd),
    .wr_if (wr)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] model [4096];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [5:0]  size;
    logic [7:0]  base;
    logic [7:0]  step;
    int          lat;
    logic [7:0]  b0;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int eff(input logic [5:0] s);
    return (s > 6'd32) ? 32 : int'(s);
  endfunction

  function automatic mem_line_t model_read(input logic [11:0] a, input logic [5:0] s);
    mem_line_t r;
    r = '0;
    for (int i = 0; i < eff(s); i++) r[i] = model[(int'(a) + i) % 4096];
    return r;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [5:0] s, input mem_line_t d);
    for (int j = 0; j < eff(s); j++) model[(int'(a) + j) % 4096] = d[j];
  endtask

  function automatic int exp_lat(input bit w, input logic [11:0] a, input logic [5:0] s);
    bit span;
    span = ((int'(a) % 32) + eff(s)) > 32;
    if (w) return span ? 3 : 2;
    return span ? 4 : 3;
  endfunction

  // Issues one request from IDLE, drops it after acceptance and scrambles the inputs,
  // then counts cycles to the response pulse.
  task automatic do_op(input bit is_wr, input logic [11:0] a, input logic [5:0] s,
                       input mem_line_t d, output mem_line_t q, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    q   = '0;
    if (is_wr) begin
      wr.mem_req = 1'b1; wr.mem_start_addr = a; wr.mem_size_bytes = s; wr.mem_data = d;
    end else begin
      rd.mem_req = 1'b1; rd.mem_start_addr = a; rd.mem_size_bytes = s;
    end
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      rd.mem_req = 1'b0;
      wr.mem_req = 1'b0;
      rd.mem_start_addr = 12'($urandom);
      wr.mem_start_addr = 12'($urandom);
      rd.mem_size_bytes = 6'($urandom);
      wr.mem_size_bytes = 6'($urandom);
      wr.mem_data = {8{$urandom}};
      if (is_wr ? wr.mem_ack : rd.mem_valid) begin
        got = 1'b1;
        q   = rd.mem_data;
      end
    end
    if (!got) lat = 99;
    @(negedge clk);
    chk("single-cycle pulse", 256'({rd.mem_valid, wr.mem_ack}), 256'(0));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [19];
    mem_line_t   d, q, e;
    int          lat, ack_n, val_n, ack_cnt;
    bit          w, saw;
    logic [11:0] a;
    logic [5:0]  s;

    tbl[0]  = '{1'b1, 12'h040, 6'd32, 8'h00, 8'h01, 2, 8'h00};
    tbl[1]  = '{1'b0, 12'h040, 6'd32, 8'h00, 8'h00, 3, 8'h00};
    tbl[2]  = '{1'b1, 12'h040, 6'd32, 8'h40, 8'h01, 2, 8'h00};
    tbl[3]  = '{1'b0, 12'h05C, 6'd8,  8'h00, 8'h00, 4, 8'h5C};
    tbl[4]  = '{1'b1, 12'h045, 6'd3,  8'hAA, 8'h11, 2, 8'h00};
    tbl[5]  = '{1'b0, 12'h040, 6'd32, 8'h00, 8'h00, 3, 8'h40};
    tbl[6]  = '{1'b1, 12'h05E, 6'd4,  8'h10, 8'h01, 3, 8'h00};
    tbl[7]  = '{1'b0, 12'h05C, 6'd8,  8'h00, 8'h00, 4, 8'h5C};
    tbl[8]  = '{1'b0, 12'h040, 6'd0,  8'h00, 8'h00, 3, 8'h00};
    tbl[9]  = '{1'b1, 12'h060, 6'd40, 8'h80, 8'h01, 2, 8'h00};
    tbl[10] = '{1'b0, 12'h080, 6'd8,  8'h00, 8'h00, 3, 8'h80};
    tbl[11] = '{1'b0, 12'h060, 6'd40, 8'h00, 8'h00, 3, 8'h80};
    tbl[12] = '{1'b0, 12'hFFC, 6'd8,  8'h00, 8'h00, 4, 8'hFC};
    tbl[13] = '{1'b1, 12'hFFE, 6'd4,  8'h55, 8'h01, 3, 8'h00};
    tbl[14] = '{1'b0, 12'hFFC, 6'd8,  8'h00, 8'h00, 4, 8'hFC};
    tbl[15] = '{1'b1, 12'h07F, 6'd1,  8'h99, 8'h01, 2, 8'h00};
    tbl[16] = '{1'b0, 12'h07F, 6'd2,  8'h00, 8'h00, 4, 8'h99};
    tbl[17] = '{1'b1, 12'h100, 6'd0,  8'h77, 8'h01, 2, 8'h00};
    tbl[18] = '{1'b0, 12'h100, 6'd32, 8'h00, 8'h00, 3, 8'h00};

    rd.mem_req = 1'b0; rd.mem_start_addr = '0; rd.mem_size_bytes = '0;
    wr.mem_req = 1'b0; wr.mem_start_addr = '0; wr.mem_size_bytes = '0; wr.mem_data = '0;

    repeat (2) @(negedge clk);
    chk("reset data", rd.mem_data, '0);
    chk("reset valid/ack", 256'({rd.mem_valid, wr.mem_ack}), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Both clients in the first IDLE: write first, then read, held write not repeated.
    for (int b = 0; b < 32; b++) e[b] = 8'h11;
    wr.mem_req = 1'b1; wr.mem_start_addr = 12'h080; wr.mem_size_bytes = 6'd32; wr.mem_data = e;
    rd.mem_req = 1'b1; rd.mem_start_addr = 12'h080; rd.mem_size_bytes = 6'd32;
    ack_n = 0; val_n = 0; ack_cnt = 0; q = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (wr.mem_ack) begin
        ack_cnt++;
        if (ack_n == 0) ack_n = n;
      end
      if (rd.mem_valid && val_n == 0) begin
        val_n = n;
        q = rd.mem_data;
        rd.mem_req = 1'b0;
        wr.mem_req = 1'b0;
      end
    end
    chk("arb write ack cycle", 256'(ack_n), 256'(2));
    chk("arb read valid cycle", 256'(val_n), 256'(6));
    chk("arb read data", q, e);
    chk("arb ack count", 256'(ack_cnt), 256'(1));
    model_write(12'h080, 6'd32, e);

    for (int l = 0; l < 128; l++) begin
      for (int b = 0; b < 32; b++) d[b] = 8'(l * 32 + b);
      do_op(1'b1, 12'(l * 32), 6'd32, d, q, lat);
      chk($sformatf("init line %0d lat", l), 256'(lat), 256'(2));
      model_write(12'(l * 32), 6'd32, d);
    end

    for (int r = 0; r < 19; r++) begin
      for (int b = 0; b < 32; b++) d[b] = 8'(int'(tbl[r].base) + b * int'(tbl[r].step));
      do_op(tbl[r].wr, tbl[r].addr, tbl[r].size, d, q, lat);
      chk($sformatf("vec%0d latency", r), 256'(lat), 256'(tbl[r].lat));
      if (tbl[r].wr) begin
        model_write(tbl[r].addr, tbl[r].size, d);
      end else begin
        chk($sformatf("vec%0d data", r), q, model_read(tbl[r].addr, tbl[r].size));
        chk($sformatf("vec%0d byte0", r), 256'(q[0]), 256'(tbl[r].b0));
      end
    end

    for (int k = 0; k < 200; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      s = 6'($urandom_range(0, 40));
      for (int b = 0; b < 32; b++) d[b] = 8'($urandom);
      do_op(w, a, s, d, q, lat);
      chk($sformatf("rand%0d latency a=%h s=%0d", k, a, s), 256'(lat), 256'(exp_lat(w, a, s)));
      if (w) model_write(a, s, d);
      else   chk($sformatf("rand%0d data a=%h s=%0d", k, a, s), q, model_read(a, s));
    end

    // Reset while the split read is in RD1: no response, outputs cleared.
    rd.mem_req = 1'b1; rd.mem_start_addr = 12'h05C; rd.mem_size_bytes = 6'd8;
    @(negedge clk);
    rd.mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-op reset data", rd.mem_data, '0);
    chk("mid-op reset valid/ack", 256'({rd.mem_valid, wr.mem_ack}), 256'(0));
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rd.mem_valid | wr.mem_ack) saw = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rd.mem_valid | wr.mem_ack) saw = 1'b1;
    end
    chk("no response after mid-op reset", 256'(saw), 256'(0));
    chk("data held zero after reset", rd.mem_data, '0);
    do_op(1'b0, 12'h040, 6'd32, d, q, lat);
    chk("post-reset read latency", 256'(lat), 256'(3));
    chk("post-reset read data", q, model_read(12'h040, 6'd32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
